// File: rtl/video_pattern_pkg.sv
// ---------------------------------------------------------------------------
// video_pattern_pkg
// Shared definitions for the video test-pattern generator:
//   - mode_e      : pattern-select encodings carried on i_mode
//   - BAR_TABLE   : the eight colour-bar colours, one bit per channel {R,G,B}
//   - bar_color() : bar index (0..7, 8 = past the last bar) to 1-bit RGB
// ---------------------------------------------------------------------------
package video_pattern_pkg;

    typedef enum logic [2:0] {
        MODE_BARS    = 3'd0,
        MODE_CHECKER = 3'd1,
        MODE_HRAMP   = 3'd2,
        MODE_VRAMP   = 3'd3,
        MODE_SOLID   = 3'd4,
        MODE_BORDER  = 3'd5,
        MODE_RSVD6   = 3'd6,
        MODE_RSVD7   = 3'd7
    } mode_e;

    // Index value meaning "to the right of the eighth bar" (always black).
    localparam logic [3:0] BAR_NONE = 4'd8;

    // Entry i lives at bits [3*i+2 : 3*i], each entry is {R,G,B}.
    // Order from bar 0: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_TABLE = {
        3'b000,   // 7 black
        3'b001,   // 6 blue
        3'b100,   // 5 red
        3'b101,   // 4 magenta
        3'b010,   // 3 green
        3'b011,   // 2 cyan
        3'b110,   // 1 yellow
        3'b111    // 0 white
    };

    function automatic logic [2:0] bar_color(input logic [3:0] idx);
        logic [4:0] base;
        base = {2'b00, idx[2:0]} * 5'd3;
        if (idx[3]) begin
            return 3'b000;
        end else begin
            return BAR_TABLE[base +: 3];
        end
    endfunction

endpackage

// File: rtl/video_pattern_bars.sv
// ---------------------------------------------------------------------------
// video_pattern_bars
// Colour-bar engine. Tracks the position inside the current bar with a
// bar-width counter and the bar index, so no divider is needed.
//
// color_next is the bar colour for the position the line will be at after
// this clock edge; the parent registers it into its pixel register, which
// gives the required one-cycle latency without an extra pipeline stage.
//
// Ports
//   clk, rst_n  : pixel clock, async active-low reset
//   bar_w       : bar width in pixels (frame width >> 3), 0 = no bars
//   load        : line/frame start; position restarts at load_x
//   load_x      : starting horizontal position of the line
//   step        : horizontal position advances by one
//   wrap        : with step, position wraps back to 0
//   color_next  : {R,G,B} one bit per channel for the next position
// ---------------------------------------------------------------------------
module video_pattern_bars
#(
    parameter int HW = 12
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [HW-1:0] bar_w,
    input  logic          load,
    input  logic [HW-1:0] load_x,
    input  logic          step,
    input  logic          wrap,
    output logic [2:0]    color_next
);
    import video_pattern_pkg::*;

    logic [HW-1:0] cnt_r;
    logic [HW-1:0] cnt_n_s;
    logic [3:0]    idx_r;
    logic [3:0]    idx_n_s;
    logic [HW:0]   cnt_inc_s;
    logic [HW+3:0] acc_s;
    logic [HW-1:0] base_s;
    logic [3:0]    load_idx_s;

    // Locate load_x on the bar grid by accumulating bar widths: the bar index
    // is the number of whole bars that fit before load_x, capped at eight.
    always_comb begin
        acc_s      = {(HW+4){1'b0}};
        base_s     = {HW{1'b0}};
        load_idx_s = 4'd0;
        for (int k = 0; k < 8; k++) begin
            acc_s = acc_s + {4'b0000, bar_w};
            if (acc_s <= {4'b0000, load_x}) begin
                load_idx_s = load_idx_s + 4'd1;
                base_s     = acc_s[HW-1:0];
            end else begin
                load_idx_s = load_idx_s;
                base_s     = base_s;
            end
        end
    end

    // Next bar index / in-bar counter.
    always_comb begin
        cnt_inc_s = {1'b0, cnt_r} + {{HW{1'b0}}, 1'b1};
        if (load) begin
            idx_n_s = load_idx_s;
            cnt_n_s = load_x - base_s;
        end else if (step && wrap) begin
            // A zero bar width means the whole line is past the bars.
            idx_n_s = (bar_w == {HW{1'b0}}) ? BAR_NONE : 4'd0;
            cnt_n_s = {HW{1'b0}};
        end else if (step && !idx_r[3]) begin
            if (cnt_inc_s == {1'b0, bar_w}) begin
                idx_n_s = idx_r + 4'd1;
                cnt_n_s = {HW{1'b0}};
            end else begin
                idx_n_s = idx_r;
                cnt_n_s = cnt_inc_s[HW-1:0];
            end
        end else begin
            idx_n_s = idx_r;
            cnt_n_s = cnt_r;
        end
    end

    // Bar position state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r <= BAR_NONE;
            cnt_r <= {HW{1'b0}};
        end else begin
            idx_r <= idx_n_s;
            cnt_r <= cnt_n_s;
        end
    end

    assign color_next = bar_color(idx_n_s);

endmodule

// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
// Test-pattern source for an HDMI encoder. Keeps x/y counters driven by the
// encoder's i_rd / i_newline / i_newframe strobes and presents the pixel for
// the current (x, y) on a registered output.
//
// Ports
//   i_pixclk            : pixel clock
//   i_reset_n           : async active-low reset; output stays black until
//                         the next i_newframe
//   i_width, i_height   : active frame size, latched on i_newframe
//   i_mode              : pattern select (video_pattern_pkg::mode_e),
//                         latched on i_newframe
//   i_solid             : solid colour {R,G,B}, used live in MODE_SOLID
//   i_rd                : pixel consumed, x advances (saturates at width-1)
//   i_newline           : x to 0, y advances (saturates at height-1)
//   i_newframe          : x,y to 0, frame counter +1, latch mode/size
//   o_pixel             : registered pixel {R,G,B}
//   o_frame_cnt         : 8-bit frame counter
//
// Build option
//   PATGEN_ANIM_EN : when defined, bars/checker/horizontal ramp use
//                    x' = (x + o_frame_cnt) mod width so the pattern scrolls
//                    one pixel per frame. Undefined: x' = x.
// ---------------------------------------------------------------------------
module video_pattern_gen
#(
    parameter int BITS_PER_COLOR = 8,
    parameter int HW             = 12,
    parameter int CHECK_LG       = 5
)
(
    input  logic                        i_pixclk,
    input  logic                        i_reset_n,
    input  logic [HW-1:0]               i_width,
    input  logic [HW-1:0]               i_height,
    input  logic [2:0]                  i_mode,
    input  logic [3*BITS_PER_COLOR-1:0] i_solid,
    input  logic                        i_rd,
    input  logic                        i_newline,
    input  logic                        i_newframe,
    output logic [3*BITS_PER_COLOR-1:0] o_pixel,
    output logic [7:0]                  o_frame_cnt
);
    import video_pattern_pkg::*;

    localparam int            PW     = 3 * BITS_PER_COLOR;
    localparam logic [HW-1:0] HW_ONE = {{(HW-1){1'b0}}, 1'b1};

    // Registered state
    logic [HW-1:0] x_r;
    logic [HW-1:0] y_r;
    logic [HW-1:0] width_r;
    logic [HW-1:0] height_r;
    mode_e         mode_r;
    logic [7:0]    fc_r;
    logic          valid_r;
    logic [PW-1:0] pixel_r;

    // Next-state values (what the registers hold after this edge)
    logic [HW-1:0] x_n_s;
    logic [HW-1:0] y_n_s;
    logic [HW-1:0] xa_n_s;
    logic [HW-1:0] width_n_s;
    logic [HW-1:0] height_n_s;
    mode_e         mode_n_s;
    logic [7:0]    fc_n_s;
    logic          valid_n_s;
    logic          line_start_s;
    logic          step_s;
    logic [HW:0]   x_inc_s;
    logic [HW:0]   y_inc_s;

    // Bar engine hookup
    logic [HW-1:0] bar_w_s;
    logic [HW-1:0] load_x_s;
    logic          bar_wrap_s;
    logic [2:0]    bar_rgb_s;

    logic [PW-1:0] pix_s;
    logic          border_s;

    function automatic logic [PW-1:0] expand(input logic [2:0] rgb);
        return {{BITS_PER_COLOR{rgb[2]}}, {BITS_PER_COLOR{rgb[1]}}, {BITS_PER_COLOR{rgb[0]}}};
    endfunction

    // Low BITS_PER_COLOR bits of a counter as a grey level.
    function automatic logic [BITS_PER_COLOR-1:0] ramp(input logic [HW-1:0] v);
        return BITS_PER_COLOR'(v);
    endfunction

    // Counter next-state: newframe beats newline beats rd.
    always_comb begin
        line_start_s = i_newframe | i_newline;
        x_inc_s      = {1'b0, x_r} + {{HW{1'b0}}, 1'b1};
        y_inc_s      = {1'b0, y_r} + {{HW{1'b0}}, 1'b1};
        // Compare against width in HW+1 bits so a zero width never advances.
        step_s       = i_rd & ~line_start_s & (x_inc_s < {1'b0, width_r});
        valid_n_s    = valid_r | i_newframe;

        if (i_newframe) begin
            width_n_s  = i_width;
            height_n_s = i_height;
            mode_n_s   = mode_e'(i_mode);
            fc_n_s     = fc_r + 8'd1;
        end else begin
            width_n_s  = width_r;
            height_n_s = height_r;
            mode_n_s   = mode_r;
            fc_n_s     = fc_r;
        end

        if (line_start_s) begin
            x_n_s = {HW{1'b0}};
        end else if (step_s) begin
            x_n_s = x_inc_s[HW-1:0];
        end else begin
            x_n_s = x_r;
        end

        if (i_newframe) begin
            y_n_s = {HW{1'b0}};
        end else if (i_newline && (y_inc_s < {1'b0, height_r})) begin
            y_n_s = y_inc_s[HW-1:0];
        end else begin
            y_n_s = y_r;
        end
    end

    assign bar_w_s = {3'b000, width_n_s[HW-1:3]};

`ifdef PATGEN_ANIM_EN
    logic [HW-1:0] xa_r;
    logic [HW:0]   xa_inc_s;

    // fc mod w by 8-step restoring remainder (fc is only 8 bits wide).
    function automatic logic [HW-1:0] frame_offset(input logic [7:0] fc, input logic [HW-1:0] w);
        logic [HW:0] r;
        r = {(HW+1){1'b0}};
        for (int i = 7; i >= 0; i--) begin
            r = {r[HW-1:0], fc[i]};
            if (r >= {1'b0, w}) begin
                r = r - {1'b0, w};
            end else begin
                r = r;
            end
        end
        return r[HW-1:0];
    endfunction

    // Scrolled x' = (x + frame count) mod width, maintained incrementally:
    // seeded at line start, then advanced with wrap alongside x.
    always_comb begin
        load_x_s   = frame_offset(fc_n_s, width_n_s);
        xa_inc_s   = {1'b0, xa_r} + {{HW{1'b0}}, 1'b1};
        bar_wrap_s = step_s & (xa_inc_s >= {1'b0, width_r});
        if (line_start_s) begin
            xa_n_s = load_x_s;
        end else if (bar_wrap_s) begin
            xa_n_s = {HW{1'b0}};
        end else if (step_s) begin
            xa_n_s = xa_inc_s[HW-1:0];
        end else begin
            xa_n_s = xa_r;
        end
    end

    // Scrolled x register.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            xa_r <= {HW{1'b0}};
        end else begin
            xa_r <= xa_n_s;
        end
    end
`else
    // Without scrolling the pattern x is simply x; lines always start at 0.
    always_comb begin
        load_x_s   = {HW{1'b0}};
        bar_wrap_s = 1'b0;
        xa_n_s     = x_n_s;
    end
`endif

    video_pattern_bars #(
        .HW (HW)
    ) u_bars (
        .clk        (i_pixclk),
        .rst_n      (i_reset_n),
        .bar_w      (bar_w_s),
        .load       (line_start_s),
        .load_x     (load_x_s),
        .step       (step_s),
        .wrap       (bar_wrap_s),
        .color_next (bar_rgb_s)
    );

    // Pattern pixel for the next (x, y).
    always_comb begin
        border_s = (x_n_s == {HW{1'b0}}) ||
                   (x_n_s == (width_n_s - HW_ONE)) ||
                   (y_n_s == {HW{1'b0}}) ||
                   (y_n_s == (height_n_s - HW_ONE)) ||
                   (x_n_s == {1'b0, width_n_s[HW-1:1]}) ||
                   (y_n_s == {1'b0, height_n_s[HW-1:1]});
        pix_s = {PW{1'b0}};
        case (mode_n_s)
            MODE_BARS:    pix_s = expand(bar_rgb_s);
            MODE_CHECKER: pix_s = (xa_n_s[CHECK_LG] ^ y_n_s[CHECK_LG]) ? {PW{1'b0}} : {PW{1'b1}};
            MODE_HRAMP:   pix_s = {3{ramp(xa_n_s)}};
            MODE_VRAMP:   pix_s = {3{ramp(y_n_s)}};
            MODE_SOLID:   pix_s = i_solid;
            MODE_BORDER:  pix_s = border_s ? {PW{1'b1}} : {PW{1'b0}};
            default:      pix_s = {PW{1'b0}};
        endcase
    end

    // Frame/line state and the registered output pixel. Until a frame has
    // started since reset the output is forced black.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x_r      <= {HW{1'b0}};
            y_r      <= {HW{1'b0}};
            width_r  <= {HW{1'b0}};
            height_r <= {HW{1'b0}};
            mode_r   <= MODE_BARS;
            fc_r     <= 8'd0;
            valid_r  <= 1'b0;
            pixel_r  <= {PW{1'b0}};
        end else begin
            x_r      <= x_n_s;
            y_r      <= y_n_s;
            width_r  <= width_n_s;
            height_r <= height_n_s;
            mode_r   <= mode_n_s;
            fc_r     <= fc_n_s;
            valid_r  <= valid_n_s;
            pixel_r  <= valid_n_s ? pix_s : {PW{1'b0}};
        end
    end

    assign o_pixel     = pixel_r;
    assign o_frame_cnt = fc_r;

endmodule
